// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-bus types: access sizes and the bus arbiter state encoding.
package mem_bus_arbiter_pkg;

    // MSIZE4 encodes as zero so a cleared request field reads as a full word.
    typedef enum logic [1:0] {
        MSIZE4 = 2'd0,
        MSIZE1 = 2'd1,
        MSIZE2 = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int unsigned StarveCntW = 3;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-beat memory bus arbiter between fetch (I) and memory stage (D) requesters.
// Data side has priority; a starvation counter guarantees fetch progress.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ireq_valid,
    input  logic [31:0] ireq_addr,
    output logic        iresp_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [31:0] dreq_addr,
    input  logic [3:0]  dreq_strobe,
    input  msize_t      dreq_size,
    input  logic [31:0] dreq_wdata,
    output logic        dresp_ok,
    output logic [31:0] dresp_data,
    output logic        creq_valid,
    output logic [31:0] creq_addr,
    output logic [3:0]  creq_strobe,
    output msize_t      creq_size,
    output logic [31:0] creq_wdata,
    input  logic        cresp_ok,
    input  logic [31:0] cresp_data
);

    localparam logic [StarveCntW-1:0] Limit = StarveCntW'(STARVE_LIMIT);

    arb_state_t            state;
    logic [StarveCntW-1:0] starve_cnt;
    logic                  aborted;
    logic                  grant_i;
    logic                  grant_d;
    logic                  owner_valid;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (ireq_valid && (starve_cnt == Limit)) begin
                grant_i = 1'b1;
            end else if (dreq_valid) begin
                grant_d = 1'b1;
            end else if (ireq_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    assign owner_valid = (state == BUSY_I) ? ireq_valid : dreq_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            aborted     <= 1'b0;
            creq_valid  <= 1'b0;
            creq_addr   <= '0;
            creq_strobe <= '0;
            creq_size   <= MSIZE4;
            creq_wdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    aborted <= 1'b0;
                    if (!ireq_valid || grant_i) begin
                        starve_cnt <= '0;
                    end else if (grant_d && (starve_cnt != Limit)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                    if (grant_i) begin
                        state       <= BUSY_I;
                        creq_valid  <= 1'b1;
                        creq_addr   <= ireq_addr;
                        creq_strobe <= '0;
                        creq_size   <= MSIZE4;
                        creq_wdata  <= '0;
                    end else if (grant_d) begin
                        state       <= BUSY_D;
                        creq_valid  <= 1'b1;
                        creq_addr   <= dreq_addr;
                        creq_strobe <= dreq_strobe;
                        creq_size   <= dreq_size;
                        creq_wdata  <= dreq_wdata;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (cresp_ok) begin
                        state       <= IDLE;
                        aborted     <= 1'b0;
                        creq_valid  <= 1'b0;
                        creq_addr   <= '0;
                        creq_strobe <= '0;
                        creq_size   <= MSIZE4;
                        creq_wdata  <= '0;
                    end else if (!owner_valid) begin
                        // Owner withdrew: let the bus finish but drop its response.
                        aborted <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iresp_ok   = resetn && cresp_ok && (state == BUSY_I) && !aborted;
        dresp_ok   = resetn && cresp_ok && (state == BUSY_D) && !aborted;
        iresp_data = iresp_ok ? cresp_data : '0;
        dresp_data = dresp_ok ? cresp_data : '0;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one single-beat memory bus between the fetch stage (instruction requester) and the memory stage (data requester, driven from the M-stage `m_vreq`, `m_write_data`, `m_data_size`, `m_valo` signals). It registers one request at a time, sequences it onto the bus and routes the response back to the owner. Data requests have priority, with a starvation limit that protects fetch. Responses to a requester that withdraws mid-transaction are dropped.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive data grants made while an instruction request waits; once reached, the instruction side wins the next arbitration.
- `clk` input 1: clock.
- `resetn` input 1: reset, synchronous, active-low.
- `ireq_valid` input 1: fetch request; held stable until `iresp_ok` or withdrawn.
- `ireq_addr` input 32: fetch address.
- `iresp_ok` output 1: one-cycle pulse; fetch data is valid.
- `iresp_data` output 32: fetch data; valid only with `iresp_ok`.
- `dreq_valid` input 1: data request; held stable until `dresp_ok` or withdrawn.
- `dreq_addr` input 32: data address.
- `dreq_strobe` input 4: byte write enables; 0 means read.
- `dreq_size` input `msize_t`: access size.
- `dreq_wdata` input 32: store data, already lane-replicated.
- `dresp_ok` output 1: one-cycle pulse; load data / store completion.
- `dresp_data` output 32: load data; valid only with `dresp_ok`.
- `creq_valid` output 1: bus request; held until `cresp_ok`.
- `creq_addr` output 32: bus address.
- `creq_strobe` output 4: bus byte enables.
- `creq_size` output `msize_t`: bus access size.
- `creq_wdata` output 32: bus write data.
- `cresp_ok` input 1: bus completion pulse.
- `cresp_data` input 32: bus read data.

## Operation
- **States.**
  - `IDLE`: no transaction outstanding.
  - `BUSY_I`: an instruction transaction is on the bus.
  - `BUSY_D`: a data transaction is on the bus.
- **Arbitration in `IDLE`.**
  - If `ireq_valid` and `starve_cnt == STARVE_LIMIT`, grant I.
  - Otherwise, if `dreq_valid`, grant D.
  - Otherwise, if `ireq_valid`, grant I.
  - Otherwise stay in `IDLE`.
- **Grant.** On a grant the arbiter captures the address, strobe, size and wdata into `creq_*` registers and moves to the matching `BUSY` state. Instruction grants use strobe 0 and `MSIZE4`.
- **Starvation counter `starve_cnt` (3 bits).**
  - Increments on a D grant while `ireq_valid` is high, saturating at `STARVE_LIMIT`.
  - Clears on an I grant.
  - Clears on any `IDLE` cycle with `ireq_valid` low.
- **Completion.** In `BUSY_x`, `cresp_ok` ends the transaction: state returns to `IDLE`, `creq_valid` drops and `creq_*` fields are zeroed.
- **Response routing.** `x_resp_ok = cresp_ok & (state == BUSY_x) & ~aborted`. `x_resp_data = cresp_data` when `x_resp_ok`, otherwise 0.
- **Withdrawal (abort).**
  - If the owner's `x_req_valid` is low during `BUSY_x`, the `aborted` flag is set. This covers exception flush and branch redirect.
  - The bus transaction still completes and its response is discarded.
  - `aborted` clears on the completion cycle.
  - A request re-raised during the abort is not served until `IDLE`.
- **No preemption.** Exactly one bus transaction is outstanding at any time.

## Timing
- **Reset.** Applies on the clock edge with `resetn` low, even mid-transaction.
  - State goes to `IDLE`; `starve_cnt` and `aborted` go to 0.
  - All outputs are 0 (`creq_valid`, `creq_*`, `iresp_*`, `dresp_*`); `creq_size` is `MSIZE4`.
  - Any bus response arriving after reset is ignored.
- **Request to bus.** Request seen in `IDLE` at cycle T drives `creq_valid` at T+1, from registers.
- **Response path.** Combinational from `cresp_ok`: a completion at T+k gives `resp_ok` at T+k.
- **Minimum turnaround.** With `cresp_ok` at T+1, the next arbitration happens at T+2. The peak rate is one transaction per 2 cycles.
- **Simultaneous requests.** I and D in the same `IDLE` cycle: D wins unless the starvation limit has been reached.
- **`cresp_ok` in `IDLE`.** Spurious; ignored, and no `resp_ok` pulse is generated.
- **`creq_*` stability.** Fields stay stable for the whole time `creq_valid` is high.

## Structure
- `msize_t` (`MSIZE1`, `MSIZE2`, `MSIZE4`) is taken from the shared package.
- The new state enum `arb_state_t` (`IDLE`, `BUSY_I`, `BUSY_D`) is added to the same package.
- The block is a single module with no sub-modules. Arbitration decision, FSM and response routing are separate always blocks.

## Test plan
- **Single load.** `dreq_valid` with addr `0x1000`, strobe 0; the bus returns `0xDEADBEEF` two cycles after `creq_valid`.
  - Expect `creq_addr = 0x1000` at T+1.
  - Expect `dresp_ok` with `0xDEADBEEF` at T+3.
  - Expect `iresp_ok` to stay 0.
- **Simultaneous I and D.** Both requests at T.
  - Expect D served first; I gets `creq_valid` one cycle after the D completion.
- **Starvation limit.** `STARVE_LIMIT = 4`, with I and D held continuously.
  - Expect grant order D, D, D, D, I, D.
- **Fetch withdrawal.** `ireq_valid` dropped during `BUSY_I`.
  - Expect the bus completion to produce no `iresp_ok`.
  - Expect a following D request to be granted normally.
- **Store fields.** Store with strobe `0b0100`, size `MSIZE1`, wdata `0x5A5A5A5A`.
  - Expect `creq_*` to match exactly and stay stable until `cresp_ok`.
- **Reset mid-operation.** `resetn` low during `BUSY_D`.
  - Expect all outputs 0 the next cycle.
  - Expect a late `cresp_ok` to produce no `resp_ok`.
